// File: rtl/uart_rx.sv
// 8N1 serial receiver in the pixel-clock domain. Each good byte is presented on
// data_rx with a one-cycle wr_rx strobe; glitches and bad frames never strobe.
module uart_rx #(
  parameter int CLKS_PER_BIT = 273,
  parameter int HALF_BIT     = (CLKS_PER_BIT - 1) / 2
) (
  input  logic       px_clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_rx,
  output logic       wr_rx,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT);
  localparam logic [CW-1:0] CNT_SYNC = CW'(CLKS_PER_BIT - 1 - HALF_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rxState_t;

  rxState_t state, stateNext;

  logic          rx_s1, rx_s, rxPrev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bitTick, lineEdge, inBit;

  assign bitTick  = (cnt == CNT_LAST);
  assign lineEdge = rx_s ^ rxPrev;
  assign inBit    = (state == DATA) || (state == STOP);

  always_ff @(posedge px_clk) begin
    if (rst) begin
      rx_s1  <= 1'b1;
      rx_s   <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rx_s1  <= rx;
      rx_s   <= rx_s1;
      rxPrev <= rx_s;
    end
  end

  always_ff @(posedge px_clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (!rx_s) stateNext = START;
      START:   if (cnt == CNT_HALF) stateNext = rx_s ? IDLE : DATA;
      DATA:    if (bitTick && (bit_idx == 3'd7)) stateNext = STOP;
      STOP:    if (bitTick) stateNext = rx_s ? IDLE : BREAK;
      BREAK:   if (rx_s) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // A line transition inside a bit re-centres cnt so the next sample lands
  // mid-bit. At exact baud cnt already holds CNT_SYNC there, so timing is unchanged.
  always_ff @(posedge px_clk) begin
    if (rst) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data_rx   <= '0;
      wr_rx     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_rx     <= 1'b0;
      frame_err <= 1'b0;

      if ((stateNext != state) || (inBit && bitTick)) cnt <= '0;
      else if (inBit && lineEdge)                     cnt <= CNT_SYNC;
      else if (state == START || inBit)               cnt <= cnt + 1'b1;
      else                                            cnt <= '0;

      if (state == START && stateNext == DATA) bit_idx <= '0;

      if (state == DATA && bitTick) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end

      if (state == STOP && bitTick) begin
        if (rx_s) begin
          data_rx <= shreg;
          wr_rx   <= 1'b1;
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy = (state != IDLE);
  end

endmodule
